// File: rtl/pkt_rx_rd_sched.sv
// pkt_rx_rd_sched
// Read-side scheduler for the per-channel packet receive buffers. Round-robins
// over channels that have a descriptor waiting, pops one descriptor, streams
// the packet words out of that channel's RAM and presents them as a single
// backpressured word stream tagged with sof/eof and the source channel.
//
// Ports:
//   clk, rst          sole clock; synchronous active-high reset
//   cfg_chan_en       per-channel service enable
//   pkt_rdy           per-channel descriptor FIFO non-empty (registered)
//   fifo_rden         one-hot descriptor pop pulse
//   fifo_dout_bus     descriptors, 24 bits per channel: [20:11] len, [10:0] addr
//   ram_raddr_bus     per-channel RAM read address
//   ram_dout_bus      per-channel RAM data, valid 2 cycles after the address
//   out_data/out_vld/out_rdy/out_sof/out_eof/out_chan  output word stream
//   pkt_done          pulse after the eof word has transferred
//   err_zero_len      pulse when a zero-length descriptor is dropped
module pkt_rx_rd_sched #(
  parameter int CHAN_NUMS  = 8,
  parameter int CHAN_W     = 3,
  parameter int RAM_DEPTH  = 11,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHAN_NUMS-1:0]          cfg_chan_en,
  input  logic [CHAN_NUMS-1:0]          pkt_rdy,
  output logic [CHAN_NUMS-1:0]          fifo_rden,
  input  logic [CHAN_NUMS*24-1:0]       fifo_dout_bus,
  output logic [CHAN_NUMS*RAM_DEPTH-1:0] ram_raddr_bus,
  input  logic [CHAN_NUMS*16-1:0]       ram_dout_bus,
  output logic [15:0]                   out_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          out_sof,
  output logic                          out_eof,
  output logic [CHAN_W-1:0]             out_chan,
  output logic                          pkt_done,
  output logic                          err_zero_len
);

  localparam int OBUF_AW = $clog2(OBUF_DEPTH);
  localparam int CNT_W   = OBUF_AW + 1;
  localparam int OCC_W   = OBUF_AW + 2;
  localparam int ENT_W   = 16 + 2 + CHAN_W;
  localparam int LEN_W   = 10;

  typedef enum logic [2:0] {
    ST_ARB   = 3'd0,
    ST_POP   = 3'd1,
    ST_DWAIT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_READ  = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [CHAN_W-1:0]      ptr_q, ptr_d;
  logic [CHAN_W-1:0]      grant_q, grant_d;
  logic                   dwait_q, dwait_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       left_q, left_d;
  logic [RAM_DEPTH-1:0]   addr_q, addr_d;
  logic [CHAN_NUMS-1:0]   rden_q, rden_d;
  logic [RAM_DEPTH-1:0]   raddr_q [CHAN_NUMS];
  logic [RAM_DEPTH-1:0]   raddr_d [CHAN_NUMS];
  logic [2:0]             rdv_q, rdv_d;
  logic [2:0]             rsof_q, rsof_d;
  logic [2:0]             reof_q, reof_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [ENT_W-1:0]       mem_q [OBUF_DEPTH];
  logic [ENT_W-1:0]       mem_d [OBUF_DEPTH];
  logic [OBUF_AW-1:0]     wptr_q, wptr_d;
  logic [OBUF_AW-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [CHAN_NUMS-1:0]   eligible_s;
  logic                   arb_found_s;
  logic [CHAN_W-1:0]      arb_sel_s;
  logic [23:0]            desc_s;
  logic [15:0]            rdata_s;
  logic [LEN_W-1:0]       desc_len_s;
  logic [RAM_DEPTH-1:0]   desc_addr_s;
  logic                   unused_desc_s;
  logic [OCC_W-1:0]       occ_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   issue_s;
  logic [ENT_W-1:0]       head_s;
  logic [ENT_W-1:0]       push_ent_s;

  // Round-robin arbiter: first eligible channel strictly after the pointer.
  // Offsets wrap in CHAN_W bits, so CHAN_NUMS is a power of two.
  always_comb begin
    eligible_s  = pkt_rdy & cfg_chan_en;
    arb_found_s = 1'b0;
    arb_sel_s   = ptr_q;
    for (int i = 0; i < CHAN_NUMS; i++) begin
      if (!arb_found_s && eligible_s[ptr_q + CHAN_W'(i + 1)]) begin
        arb_found_s = 1'b1;
        arb_sel_s   = ptr_q + CHAN_W'(i + 1);
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Select the granted channel's descriptor and RAM data.
  always_comb begin
    desc_s  = '0;
    rdata_s = '0;
    for (int i = 0; i < CHAN_NUMS; i++) begin
      if (grant_q == CHAN_W'(i)) begin
        desc_s  = fifo_dout_bus[i*24 +: 24];
        rdata_s = ram_dout_bus[i*16 +: 16];
      end else begin
        desc_s  = desc_s;
        rdata_s = rdata_s;
      end
    end
    desc_len_s    = desc_s[20:11];
    desc_addr_s   = desc_s[RAM_DEPTH-1:0];
    unused_desc_s = ^desc_s[23:21];
  end

  // Output buffer credit: buffered words plus reads still in the RAM pipe,
  // minus the word leaving this cycle, must leave room for one more read.
  always_comb begin
    occ_s   = OCC_W'(cnt_q) + OCC_W'(rdv_q[0]) + OCC_W'(rdv_q[1]) + OCC_W'(rdv_q[2]);
    pop_s   = (cnt_q != '0) && out_rdy;
    push_s  = rdv_q[2];
    issue_s = (state_q == ST_READ) && (left_q != '0) &&
              ((occ_s - OCC_W'(pop_s)) < OCC_W'(OBUF_DEPTH));
    head_s     = mem_q[rptr_q];
    push_ent_s = {rdata_s, rsof_q[2], reof_q[2], grant_q};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:   state_d = arb_found_s ? ST_POP : ST_ARB;
      ST_POP:   state_d = ST_DWAIT;
      ST_DWAIT: state_d = dwait_q ? ST_LOAD : ST_DWAIT;
      ST_LOAD:  state_d = (desc_len_s == '0) ? ST_ARB : ST_READ;
      ST_READ:  state_d = (issue_s && (left_q == LEN_W'(1))) ? ST_DRAIN : ST_READ;
      // The last read's data lands in the buffer during the cycle rdv_q[2]
      // is set, so arbitration can resume as soon as stages 0 and 1 are idle.
      ST_DRAIN: state_d = (!rdv_q[0] && !rdv_q[1]) ? ST_ARB : ST_DRAIN;
      default:  state_d = ST_ARB;
    endcase
  end

  // Per-state outputs and packet datapath next values.
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    dwait_d = dwait_q;
    len_d   = len_q;
    left_d  = left_q;
    addr_d  = addr_q;
    raddr_d = raddr_q;
    rden_d  = '0;
    err_d   = 1'b0;
    rdv_d   = {rdv_q[1:0], issue_s};
    rsof_d  = {rsof_q[1:0], issue_s && (left_q == len_q)};
    reof_d  = {reof_q[1:0], issue_s && (left_q == LEN_W'(1))};
    done_d  = pop_s && head_s[CHAN_W];
    case (state_q)
      ST_ARB: begin
        dwait_d = 1'b0;
        if (arb_found_s) begin
          ptr_d   = arb_sel_s;
          grant_d = arb_sel_s;
          for (int i = 0; i < CHAN_NUMS; i++) begin
            rden_d[i] = (arb_sel_s == CHAN_W'(i));
          end
        end else begin
          rden_d = '0;
        end
      end
      ST_DWAIT: dwait_d = ~dwait_q;
      ST_LOAD: begin
        len_d  = desc_len_s;
        left_d = desc_len_s;
        addr_d = desc_addr_s;
        err_d  = (desc_len_s == '0);
      end
      ST_READ: begin
        if (issue_s) begin
          for (int i = 0; i < CHAN_NUMS; i++) begin
            if (grant_q == CHAN_W'(i)) begin
              raddr_d[i] = addr_q;
            end else begin
              raddr_d[i] = raddr_q[i];
            end
          end
          addr_d = addr_q + RAM_DEPTH'(1);
          left_d = left_q - LEN_W'(1);
        end else begin
          addr_d = addr_q;
          left_d = left_q;
        end
      end
      default: dwait_d = dwait_q;
    endcase
  end

  // Output buffer next values: write at the tail, read at the head.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wptr_q] = push_ent_s;
      wptr_d        = wptr_q + OBUF_AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + OBUF_AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    cnt_d = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Datapath and output buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= CHAN_W'(CHAN_NUMS - 1);
      grant_q <= '0;
      dwait_q <= 1'b0;
      len_q   <= '0;
      left_q  <= '0;
      addr_q  <= '0;
      rden_q  <= '0;
      rdv_q   <= '0;
      rsof_q  <= '0;
      reof_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < CHAN_NUMS; i++) begin
        raddr_q[i] <= '0;
      end
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dwait_q <= dwait_d;
      len_q   <= len_d;
      left_q  <= left_d;
      addr_q  <= addr_d;
      rden_q  <= rden_d;
      rdv_q   <= rdv_d;
      rsof_q  <= rsof_d;
      reof_q  <= reof_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      mem_q   <= mem_d;
    end
  end

  // Drive ports from registered state; out_* reflect the buffer head.
  always_comb begin
    for (int i = 0; i < CHAN_NUMS; i++) begin
      ram_raddr_bus[i*RAM_DEPTH +: RAM_DEPTH] = raddr_q[i];
    end
    fifo_rden    = rden_q;
    out_vld      = (cnt_q != '0);
    out_data     = head_s[ENT_W-1 -: 16];
    out_sof      = head_s[CHAN_W+1];
    out_eof      = head_s[CHAN_W];
    out_chan     = head_s[CHAN_W-1:0];
    pkt_done     = done_q;
    err_zero_len = err_q;
  end

endmodule

// File: tb/tb_pkt_rx_rd_sched.sv
module tb_pkt_rx_rd_sched;
  localparam int CN = 8;
  localparam int CW = 3;
  localparam int RD = 11;
  localparam int OD = 4;

  logic              clk;
  logic              rst;
  logic [CN-1:0]     cfg_chan_en;
  logic [CN-1:0]     pkt_rdy;
  logic [CN-1:0]     fifo_rden;
  logic [CN*24-1:0]  fifo_dout_bus;
  logic [CN*RD-1:0]  ram_raddr_bus;
  logic [CN*16-1:0]  ram_dout_bus;
  logic [15:0]       out_data;
  logic              out_vld;
  logic              out_rdy;
  logic              out_sof;
  logic              out_eof;
  logic [CW-1:0]     out_chan;
  logic              pkt_done;
  logic              err_zero_len;

  pkt_rx_rd_sched #(.CHAN_NUMS(CN), .CHAN_W(CW), .RAM_DEPTH(RD), .OBUF_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .cfg_chan_en(cfg_chan_en), .pkt_rdy(pkt_rdy),
    .fifo_rden(fifo_rden), .fifo_dout_bus(fifo_dout_bus),
    .ram_raddr_bus(ram_raddr_bus), .ram_dout_bus(ram_dout_bus),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_sof(out_sof), .out_eof(out_eof), .out_chan(out_chan),
    .pkt_done(pkt_done), .err_zero_len(err_zero_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // RAM contents are a fixed function of channel and address.
  function automatic logic [15:0] ram_word(input int ch, input logic [10:0] a);
    logic [2:0] c;
    c = ch[2:0];
    return {c, 2'b10, a};
  endfunction

  // ---------------- RAM model: 2-cycle read latency ----------------
  logic [15:0] r1 [CN];
  logic [15:0] r2 [CN];
  always @(posedge clk) begin
    for (int i = 0; i < CN; i++) begin
      r1[i] <= ram_word(i, ram_raddr_bus[i*RD +: RD]);
      r2[i] <= r1[i];
    end
  end

  // ---------------- Descriptor FIFO model: 2-cycle read latency ----------------
  logic        push_en;
  logic [2:0]  push_ch;
  logic [23:0] push_data;
  logic [23:0] dmem [CN][16];
  logic [7:0]  wp [CN];
  logic [7:0]  rp [CN];
  logic [7:0]  wp_n [CN];
  logic [7:0]  rp_n [CN];
  logic [23:0] d1 [CN];
  logic [23:0] d2 [CN];

  always_comb begin
    for (int i = 0; i < CN; i++) begin
      wp_n[i] = wp[i] + ((push_en && push_ch == 3'(i)) ? 8'd1 : 8'd0);
      rp_n[i] = rp[i] + ((fifo_rden[i] && wp[i] != rp[i]) ? 8'd1 : 8'd0);
      fifo_dout_bus[i*24 +: 24] = d2[i];
      ram_dout_bus[i*16 +: 16]  = r2[i];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CN; i++) begin
        wp[i] <= 8'd0; rp[i] <= 8'd0; pkt_rdy[i] <= 1'b0; d1[i] <= 24'd0; d2[i] <= 24'd0;
      end
    end else begin
      if (push_en) dmem[push_ch][wp[push_ch][3:0]] <= push_data;
      for (int i = 0; i < CN; i++) begin
        wp[i] <= wp_n[i];
        rp[i] <= rp_n[i];
        pkt_rdy[i] <= (wp_n[i] != rp_n[i]);
        if (fifo_rden[i]) d1[i] <= dmem[i][rp[i][3:0]];
        d2[i] <= d1[i];
      end
    end
  end

  // ---------------- Scoreboard and monitor ----------------
  logic [20:0] exp_q [$];
  int          log_cyc [$];
  int          log_ch [$];
  logic [10:0] log_addr [$];
  int          rden_cnt [CN];
  int          rden_total = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          vld_cnt = 0;
  int          cyc = 0;
  int          sof_cyc = 0;
  int          last_span = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic        hold_pend;
    logic [21:0] hold_val;
    logic [10:0] last_raddr [CN];
    logic [10:0] cur;
    logic [20:0] e;
    hold_pend = 1'b0;
    hold_val  = '0;
    for (int i = 0; i < CN; i++) begin
      last_raddr[i] = 11'd0;
      rden_cnt[i]   = 0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
        for (int i = 0; i < CN; i++) last_raddr[i] = 11'd0;
      end else begin
        if (fifo_rden != '0) begin
          rden_total++;
          check_val("rden_onehot", 32'($onehot(fifo_rden)), 32'd1);
          for (int i = 0; i < CN; i++) begin
            if (fifo_rden[i]) begin
              rden_cnt[i]++;
              check_val("rden_nonempty", 32'(wp[i] != rp[i]), 32'd1);
            end
          end
        end
        if (pkt_done) done_cnt++;
        if (err_zero_len) err_cnt++;
        if (out_vld) vld_cnt++;
        for (int i = 0; i < CN; i++) begin
          cur = ram_raddr_bus[i*RD +: RD];
          if (cur != last_raddr[i]) begin
            log_cyc.push_back(cyc);
            log_ch.push_back(i);
            log_addr.push_back(cur);
            last_raddr[i] = cur;
          end
        end
        if (hold_pend)
          check_val("hold_stable", 32'({out_data, out_sof, out_eof, out_chan, out_vld}), 32'(hold_val));
        if (out_vld && out_rdy) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 21'h1FFFFF;
          check_val("word", 32'({out_data, out_sof, out_eof, out_chan}), 32'(e));
          if (out_sof) sof_cyc = cyc;
          if (out_eof) last_span = cyc - sof_cyc;
        end
        hold_pend = out_vld && !out_rdy;
        hold_val  = {out_data, out_sof, out_eof, out_chan, out_vld};
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input int ch, input int len, input int addr);
    @(posedge clk); #1;
    push_en   = 1'b1;
    push_ch   = 3'(ch);
    push_data = {3'b000, 10'(len), 11'(addr)};
    @(posedge clk); #1;
    push_en   = 1'b0;
  endtask

  task automatic expect_pkt(input int ch, input int len, input int addr);
    logic [10:0] a;
    for (int k = 0; k < len; k++) begin
      a = 11'(addr + k);
      exp_q.push_back({ram_word(ch, a), k == 0, k == len - 1, 3'(ch)});
    end
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val(tag, 32'(exp_q.size()), 32'd0);
    tick(4);
  endtask

  task automatic check_rst_outputs();
    check_val("rst_vld", 32'(out_vld), 32'd0);
    check_val("rst_data", 32'({out_data, out_sof, out_eof, out_chan}), 32'd0);
    check_val("rst_rden", 32'(fifo_rden), 32'd0);
    check_val("rst_raddr", 32'(ram_raddr_bus != '0), 32'd0);
    check_val("rst_pulses", 32'({pkt_done, err_zero_len}), 32'd0);
  endtask

  // ---------------- Test sequence ----------------
  initial begin
    int d0;
    int e0;
    int v0;
    int n;
    rst = 1'b1; out_rdy = 1'b1; cfg_chan_en = 8'hFF;
    push_en = 1'b0; push_ch = 3'd0; push_data = 24'd0;
    tick(3);
    check_rst_outputs();
    rst = 1'b0;
    tick(2);

    // Round-robin from reset: ch0, ch2, ch7 all flagged at once.
    cfg_chan_en = 8'h00;
    push_desc(0, 2, 'h040);
    push_desc(2, 2, 'h080);
    push_desc(7, 2, 'h0C0);
    tick(3);
    check_val("rr_pkt_rdy", 32'(pkt_rdy), 32'h85);
    expect_pkt(0, 2, 'h040);
    expect_pkt(2, 2, 'h080);
    expect_pkt(7, 2, 'h0C0);
    cfg_chan_en = 8'hFF;
    wait_empty("rr_drain", 200);
    check_val("rr_rden0", 32'(rden_cnt[0]), 32'd1);
    check_val("rr_rden2", 32'(rden_cnt[2]), 32'd1);
    check_val("rr_rden7", 32'(rden_cnt[7]), 32'd1);
    check_val("rr_done", 32'(done_cnt), 32'd3);
    tick(20);
    check_val("rr_no_stale_pop", 32'(rden_total), 32'd3);

    // Single packet ch0 len 4 at 0x010, re-flagging ch0.
    log_cyc.delete(); log_ch.delete(); log_addr.delete();
    d0 = done_cnt;
    push_desc(0, 4, 'h010);
    expect_pkt(0, 4, 'h010);
    wait_empty("t1_drain", 200);
    check_val("t1_nreads", 32'(log_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      check_val("t1_raddr", 32'(log_addr[k]), 32'('h010 + k));
      check_val("t1_raddr_cyc", 32'(log_cyc[k] - log_cyc[0]), 32'(k));
      check_val("t1_raddr_ch", 32'(log_ch[k]), 32'd0);
    end
    check_val("t1_done", 32'(done_cnt - d0), 32'd1);
    check_val("t1_rden0", 32'(rden_cnt[0]), 32'd2);
    check_val("t1_span", 32'(last_span), 32'd3);

    // Address wrap on ch3.
    log_cyc.delete(); log_ch.delete(); log_addr.delete();
    push_desc(3, 5, 'h7FE);
    expect_pkt(3, 5, 'h7FE);
    wait_empty("wrap_drain", 200);
    check_val("wrap_nreads", 32'(log_addr.size()), 32'd5);
    for (int k = 0; k < 5 && k < log_addr.size(); k++)
      check_val("wrap_raddr", 32'(log_addr[k]), 32'(11'('h7FE + k)));

    // Backpressure with out_rdy pattern 1,0,0,1.
    push_desc(5, 10, 'h200);
    expect_pkt(5, 10, 'h200);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      out_rdy = (n % 4 == 0) || (n % 4 == 3);
      @(posedge clk); #1;
      n++;
    end
    out_rdy = 1'b1;
    check_val("bp_drain", 32'(exp_q.size()), 32'd0);
    tick(4);

    // Sustained throughput: len 8 must stream sof..eof in 8 consecutive cycles.
    push_desc(6, 8, 'h300);
    expect_pkt(6, 8, 'h300);
    wait_empty("tput_drain", 200);
    check_val("tput_span", 32'(last_span), 32'd7);

    // Zero-length descriptor dropped, then a single-word packet.
    e0 = err_cnt; v0 = vld_cnt;
    push_desc(1, 0, 'h050);
    tick(15);
    check_val("zero_err", 32'(err_cnt - e0), 32'd1);
    check_val("zero_novld", 32'(vld_cnt - v0), 32'd0);
    push_desc(1, 1, 'h055);
    expect_pkt(1, 1, 'h055);
    wait_empty("len1_drain", 200);

    // Disabling the granted channel mid-packet lets the packet finish.
    push_desc(4, 12, 'h400);
    expect_pkt(4, 12, 'h400);
    tick(9);
    cfg_chan_en = 8'hEF;
    wait_empty("cfg_drain", 200);
    cfg_chan_en = 8'hFF;

    // Reset in the middle of a len 20 packet, then a clean ch0 packet.
    log_cyc.delete(); log_ch.delete(); log_addr.delete();
    push_desc(0, 20, 'h100);
    expect_pkt(0, 20, 'h100);
    n = 0;
    while (log_addr.size() < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("mid_in_read", 32'(log_addr.size() >= 3), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    check_rst_outputs();
    rst = 1'b0;
    tick(2);
    push_desc(0, 3, 'h020);
    expect_pkt(0, 3, 'h020);
    wait_empty("post_rst_drain", 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
